// File: rtl/control_unit.sv
// rtl/control_unit.sv - registered main instruction decoder for the single-issue MIPS-style CPU
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        reg_write_enable,
    output logic        mem_to_reg,
    output logic [4:0]  read_register_1,
    output logic [4:0]  read_register_2,
    output logic [4:0]  write_register,
    output logic        pc_increment,
    output logic        ram_read_enable,
    output logic        ram_write_enable,
    output logic        jump,
    output logic        branchnotequal,
    output logic        brachlessthat,
    output logic        branchgreaterthan,
    output logic        branchlessthanorequal,
    output logic        branchgreaterthanorequal,
    output logic        brancheq,
    output logic        jr,
    output logic        jal
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign op    = instruction[31:26];
    assign rs    = instruction[25:21];
    assign rt    = instruction[20:16];
    assign rd    = instruction[15:11];
    assign funct = instruction[5:0];

    logic [3:0] d_alu_op;
    logic       d_alu_src;
    logic       d_reg_write_enable;
    logic       d_mem_to_reg;
    logic [4:0] d_write_register;
    logic       d_pc_increment;
    logic       d_ram_read_enable;
    logic       d_ram_write_enable;
    logic       d_jump;
    logic       d_bne;
    logic       d_bltz;
    logic       d_bgtz;
    logic       d_blez;
    logic       d_bgez;
    logic       d_beq;
    logic       d_jr;
    logic       d_jal;

    // Combinational decode; anything not recognised falls through as a NOP
    always_comb begin
        d_alu_op           = ALU_ADD;
        d_alu_src          = 1'b0;
        d_reg_write_enable = 1'b0;
        d_mem_to_reg       = 1'b0;
        d_write_register   = rd;
        d_pc_increment     = 1'b1;
        d_ram_read_enable  = 1'b0;
        d_ram_write_enable = 1'b0;
        d_jump             = 1'b0;
        d_bne              = 1'b0;
        d_bltz             = 1'b0;
        d_bgtz             = 1'b0;
        d_blez             = 1'b0;
        d_bgez             = 1'b0;
        d_beq              = 1'b0;
        d_jr               = 1'b0;
        d_jal              = 1'b0;
        case (op)
            OP_RTYPE: begin
                d_reg_write_enable = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: d_alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: d_alu_op = ALU_SUB;
                    FN_AND:          d_alu_op = ALU_AND;
                    FN_OR:           d_alu_op = ALU_OR;
                    FN_XOR:          d_alu_op = ALU_XOR;
                    FN_NOR:          d_alu_op = ALU_NOR;
                    FN_SLT:          d_alu_op = ALU_SLT;
                    FN_SLTU:         d_alu_op = ALU_SLTU;
                    FN_SLL:          d_alu_op = ALU_SLL;
                    FN_SRL:          d_alu_op = ALU_SRL;
                    FN_JR: begin
                        d_jr               = 1'b1;
                        d_reg_write_enable = 1'b0;
                        d_pc_increment     = 1'b0;
                    end
                    FN_JALR: begin
                        d_jr           = 1'b1;
                        d_jal          = 1'b1;
                        d_pc_increment = 1'b0;
                    end
                    default: d_reg_write_enable = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                d_alu_src          = 1'b1;
                d_reg_write_enable = 1'b1;
                d_write_register   = rt;
                case (op)
                    OP_SLTI:  d_alu_op = ALU_SLT;
                    OP_SLTIU: d_alu_op = ALU_SLTU;
                    OP_ANDI:  d_alu_op = ALU_AND;
                    OP_ORI:   d_alu_op = ALU_OR;
                    OP_XORI:  d_alu_op = ALU_XOR;
                    OP_LUI:   d_alu_op = ALU_LUI;
                    default:  d_alu_op = ALU_ADD;
                endcase
            end
            OP_LW, OP_LB: begin
                d_alu_src          = 1'b1;
                d_write_register   = rt;
                d_ram_read_enable  = 1'b1;
                d_mem_to_reg       = 1'b1;
                d_reg_write_enable = 1'b1;
            end
            OP_SW, OP_SB: begin
                d_alu_src          = 1'b1;
                d_write_register   = rt;
                d_ram_write_enable = 1'b1;
            end
            OP_BEQ: begin
                d_alu_op = ALU_SUB;
                d_beq    = 1'b1;
            end
            OP_BNE: begin
                d_alu_op = ALU_SUB;
                d_bne    = 1'b1;
            end
            OP_BLEZ: begin
                d_alu_op = ALU_SUB;
                d_blez   = 1'b1;
            end
            OP_BGTZ: begin
                d_alu_op = ALU_SUB;
                d_bgtz   = 1'b1;
            end
            OP_REGIMM: begin
                // Only bltz (rt=0) and bgez (rt=1) exist; other rt values stay NOP
                if (rt == 5'd0) begin
                    d_alu_op = ALU_SUB;
                    d_bltz   = 1'b1;
                end else if (rt == 5'd1) begin
                    d_alu_op = ALU_SUB;
                    d_bgez   = 1'b1;
                end
            end
            OP_J: begin
                d_jump         = 1'b1;
                d_pc_increment = 1'b0;
            end
            OP_JAL: begin
                d_jump             = 1'b1;
                d_jal              = 1'b1;
                d_reg_write_enable = 1'b1;
                d_write_register   = 5'd31;
                d_pc_increment     = 1'b0;
            end
            default: ;
        endcase
    end

    // Register the decode; reset clears every output, pc_increment included
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op                   <= 4'b0000;
            alu_src                  <= 1'b0;
            reg_write_enable         <= 1'b0;
            mem_to_reg               <= 1'b0;
            read_register_1          <= 5'd0;
            read_register_2          <= 5'd0;
            write_register           <= 5'd0;
            pc_increment             <= 1'b0;
            ram_read_enable          <= 1'b0;
            ram_write_enable         <= 1'b0;
            jump                     <= 1'b0;
            branchnotequal           <= 1'b0;
            brachlessthat            <= 1'b0;
            branchgreaterthan        <= 1'b0;
            branchlessthanorequal    <= 1'b0;
            branchgreaterthanorequal <= 1'b0;
            brancheq                 <= 1'b0;
            jr                       <= 1'b0;
            jal                      <= 1'b0;
        end else begin
            alu_op                   <= d_alu_op;
            alu_src                  <= d_alu_src;
            reg_write_enable         <= d_reg_write_enable;
            mem_to_reg               <= d_mem_to_reg;
            read_register_1          <= rs;
            read_register_2          <= rt;
            write_register           <= d_write_register;
            pc_increment             <= d_pc_increment;
            ram_read_enable          <= d_ram_read_enable;
            ram_write_enable         <= d_ram_write_enable;
            jump                     <= d_jump;
            branchnotequal           <= d_bne;
            brachlessthat            <= d_bltz;
            branchgreaterthan        <= d_bgtz;
            branchlessthanorequal    <= d_blez;
            branchgreaterthanorequal <= d_bgez;
            brancheq                 <= d_beq;
            jr                       <= d_jr;
            jal                      <= d_jal;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit against a table-driven decode model
module tb_control_unit;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       rwe;
        logic       m2r;
        logic [4:0] rr1;
        logic [4:0] rr2;
        logic [4:0] wr;
        logic       pcinc;
        logic       rre;
        logic       wre;
        logic       jump;
        logic       bne;
        logic       bltz;
        logic       bgtz;
        logic       blez;
        logic       bgez;
        logic       beq;
        logic       jr;
        logic       jal;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [3:0]  alu_op;
    logic        alu_src, reg_write_enable, mem_to_reg;
    logic [4:0]  read_register_1, read_register_2, write_register;
    logic        pc_increment, ram_read_enable, ram_write_enable, jump;
    logic        branchnotequal, brachlessthat, branchgreaterthan;
    logic        branchlessthanorequal, branchgreaterthanorequal, brancheq, jr, jal;

    control_unit dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .alu_op(alu_op), .alu_src(alu_src), .reg_write_enable(reg_write_enable),
        .mem_to_reg(mem_to_reg), .read_register_1(read_register_1),
        .read_register_2(read_register_2), .write_register(write_register),
        .pc_increment(pc_increment), .ram_read_enable(ram_read_enable),
        .ram_write_enable(ram_write_enable), .jump(jump),
        .branchnotequal(branchnotequal), .brachlessthat(brachlessthat),
        .branchgreaterthan(branchgreaterthan),
        .branchlessthanorequal(branchlessthanorequal),
        .branchgreaterthanorequal(branchgreaterthanorequal),
        .brancheq(brancheq), .jr(jr), .jal(jal)
    );

    always #5 clk = ~clk;

    ctl_t obs;
    assign obs = {alu_op, alu_src, reg_write_enable, mem_to_reg,
                  read_register_1, read_register_2, write_register,
                  pc_increment, ram_read_enable, ram_write_enable, jump,
                  branchnotequal, brachlessthat, branchgreaterthan,
                  branchlessthanorequal, branchgreaterthanorequal, brancheq, jr, jal};

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] funct_alu [logic [5:0]];
    logic [3:0] iop_alu   [logic [5:0]];

    // Reference decode from the instruction-set tables; write_register is
    // only compared where the instruction defines a destination
    function automatic void model(input logic [31:0] ins, output ctl_t e, output ctl_t m);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        logic [4:0] rd;
        op = ins[31:26];
        fn = ins[5:0];
        rt = ins[20:16];
        rd = ins[15:11];
        e = '0;
        m = '1;
        m.wr = 5'd0;
        e.alu_op = 4'b0010;
        e.pcinc = 1'b1;
        e.rr1 = ins[25:21];
        e.rr2 = rt;
        if (op == 6'd0) begin
            if (funct_alu.exists(fn)) begin
                e.alu_op = funct_alu[fn]; e.rwe = 1'b1; e.wr = rd; m.wr = 5'h1f;
            end else if (fn == 6'b001000) begin
                e.jr = 1'b1; e.pcinc = 1'b0;
            end else if (fn == 6'b001001) begin
                e.jr = 1'b1; e.jal = 1'b1; e.rwe = 1'b1; e.pcinc = 1'b0;
                e.wr = rd; m.wr = 5'h1f;
            end
        end else if (iop_alu.exists(op)) begin
            e.alu_op = iop_alu[op]; e.alu_src = 1'b1; e.rwe = 1'b1; e.wr = rt; m.wr = 5'h1f;
        end else if (op == 6'b100011 || op == 6'b100000) begin
            e.alu_src = 1'b1; e.rre = 1'b1; e.m2r = 1'b1; e.rwe = 1'b1; e.wr = rt; m.wr = 5'h1f;
        end else if (op == 6'b101011 || op == 6'b101000) begin
            e.alu_src = 1'b1; e.wre = 1'b1; e.wr = rt; m.wr = 5'h1f;
        end else if (op == 6'd2) begin
            e.jump = 1'b1; e.pcinc = 1'b0;
        end else if (op == 6'd3) begin
            e.jump = 1'b1; e.jal = 1'b1; e.rwe = 1'b1; e.pcinc = 1'b0;
            e.wr = 5'd31; m.wr = 5'h1f;
        end else begin
            case (op)
                6'd4: e.beq  = 1'b1;
                6'd5: e.bne  = 1'b1;
                6'd6: e.blez = 1'b1;
                6'd7: e.bgtz = 1'b1;
                6'd1: begin
                    e.bltz = (rt == 5'd0);
                    e.bgez = (rt == 5'd1);
                end
                default: ;
            endcase
            if (e.beq | e.bne | e.blez | e.bgtz | e.bltz | e.bgez) e.alu_op = 4'b0110;
        end
    endfunction

    task automatic check(input string tag, input ctl_t o, input ctl_t e, input ctl_t m);
        n_assert++;
        assert ((o & m) === (e & m))
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o & m, e & m);
        end
    endtask

    task automatic check_bits(input string tag, input logic [15:0] o, input logic [15:0] e);
        n_assert++;
        assert (o === e)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] ins);
        ctl_t e;
        ctl_t m;
        @(negedge clk);
        instruction = ins;
        @(posedge clk);
        #1;
        model(ins, e, m);
        check(tag, obs, e, m);
    endtask

    initial begin
        logic [5:0] op_list [22];
        logic [5:0] fn_list [14];
        logic [31:0] ins;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rt;
        ctl_t e;
        ctl_t m;

        funct_alu[6'b100000] = 4'b0010; funct_alu[6'b100001] = 4'b0010;
        funct_alu[6'b100010] = 4'b0110; funct_alu[6'b100011] = 4'b0110;
        funct_alu[6'b100100] = 4'b0000; funct_alu[6'b100101] = 4'b0001;
        funct_alu[6'b100110] = 4'b0011; funct_alu[6'b100111] = 4'b0100;
        funct_alu[6'b101010] = 4'b0111; funct_alu[6'b101011] = 4'b1111;
        funct_alu[6'b000000] = 4'b0101; funct_alu[6'b000010] = 4'b1000;
        iop_alu[6'b001000] = 4'b0010; iop_alu[6'b001001] = 4'b0010;
        iop_alu[6'b001010] = 4'b0111; iop_alu[6'b001011] = 4'b1111;
        iop_alu[6'b001100] = 4'b0000; iop_alu[6'b001101] = 4'b0001;
        iop_alu[6'b001110] = 4'b0011; iop_alu[6'b001111] = 4'b1001;
        op_list = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8,
                    6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd32, 6'd35, 6'd40, 6'd43};
        fn_list = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
                    6'd42, 6'd43, 6'd0, 6'd2, 6'd8, 6'd9};

        // Reset held across edges with a jal present: everything stays 0
        reset = 1'b1;
        instruction = 32'h0C000000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", obs, '0, '1);

        // First edge after release shows the jal decode
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model(32'h0C000000, e, m);
        check("jal_after_reset", obs, e, m);
        check_bits("jal_fields", {jump, jal, write_register, pc_increment}, {8'd0, 1'b1, 1'b1, 5'd31, 1'b0});

        step("add", 32'h00002020);
        check_bits("add_fields", {alu_op, alu_src, reg_write_enable, write_register, mem_to_reg, pc_increment},
                   {3'd0, 4'b0010, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1});
        step("lw", 32'h8C040001);
        check_bits("lw_fields", {alu_op, alu_src, ram_read_enable, mem_to_reg, reg_write_enable, write_register},
                   {3'd0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4});
        step("sw", 32'hAC040001);
        check_bits("sw_fields", {ram_write_enable, reg_write_enable, alu_src}, {13'd0, 1'b1, 1'b0, 1'b1});
        step("beq", 32'h10220000);
        check_bits("beq_fields", {brancheq, alu_op, alu_src, reg_write_enable}, {9'd0, 1'b1, 4'b0110, 1'b0, 1'b0});
        step("bne", 32'h14A40000);
        check_bits("bne_flags", {jump, branchnotequal, brachlessthat, branchgreaterthan, branchlessthanorequal,
                                 branchgreaterthanorequal, brancheq, jr, jal}, 16'b0000000_010000000);
        step("jalr", 32'h00432009);
        check_bits("jalr_fields", {jr, jal, write_register, pc_increment}, {8'd0, 1'b1, 1'b1, 5'd4, 1'b0});
        step("jr", 32'h03E00008);
        step("j", 32'h08000010);
        step("bltz", 32'h04A00004);
        step("bgez", 32'h04A10004);
        step("regimm_nop", 32'h04A20004);
        step("lui", 32'h3C05ABCD);
        step("bad_funct", 32'h0043203F);
        step("bad_op", 32'hFC432000);
        step("sll_zero", 32'h00000000);

        // Reset asserted mid-cycle clears outputs without waiting for an edge
        step("pre_async", 32'h00A62025);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", obs, '0, '1);
        @(negedge clk);
        reset = 1'b0;
        step("post_async", 32'h8C240001);

        // Randomised mix of defined and undefined encodings
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = op_list[$urandom_range(0, 21)];
            if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
            else fn = fn_list[$urandom_range(0, 13)];
            rt = (op == 6'd1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ins = {op, 5'($urandom), rt, 5'($urandom), 5'($urandom), fn};
            step($sformatf("rand_%0d_%h", i, ins), ins);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
